// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage bus: MEM-side inputs, WB and forwarding outputs
interface mem_wb_stage_if #(
  parameter int data_width = 32
);
  // Pipeline control and MEM-stage instruction fields
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic                  in_reg_write;
  logic [1:0]            in_wb_sel;
  logic [1:0]            in_mem_size;
  logic                  in_mem_signed;
  logic [data_width-1:0] in_alu_result;
  logic [data_width-1:0] in_mem_rdata;
  logic [15:0]           in_imm16;
  logic [4:0]            in_dest;

  // Register-file write port, forwarding bus and status
  logic [data_width-1:0] write_data;
  logic [4:0]            write_address;
  logic                  RegWrite;
  logic [1:0]            WordPosition;
  logic                  fwd_valid;
  logic [4:0]            fwd_dest;
  logic [data_width-1:0] fwd_data;
  logic                  fwd_hazard;
  logic                  misaligned;
  logic [31:0]           retired_count;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_wb_sel, in_mem_size,
           in_mem_signed, in_alu_result, in_mem_rdata, in_imm16, in_dest,
    input  write_data, write_address, RegWrite, WordPosition, fwd_valid,
           fwd_dest, fwd_data, fwd_hazard, misaligned, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_wb_sel, in_mem_size,
           in_mem_signed, in_alu_result, in_mem_rdata, in_imm16, in_dest,
    output write_data, write_address, RegWrite, WordPosition, fwd_valid,
           fwd_dest, fwd_data, fwd_hazard, misaligned, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction, writeback mux and forwarding
module mem_wb_stage #(
  parameter int data_width = 32
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.slave  bus
);

  logic                  r_valid;
  logic                  r_reg_write;
  logic [1:0]            r_wb_sel;
  logic [1:0]            r_mem_size;
  logic                  r_mem_signed;
  logic [data_width-1:0] r_alu;
  logic [data_width-1:0] r_rdata;
  logic [15:0]           r_imm16;
  logic [4:0]            r_dest;
  logic [31:0]           r_retired_count;

  logic [1:0]            w_off;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [data_width-1:0] w_load;
  logic [data_width-1:0] w_write_data;
  logic [1:0]            w_word_pos;
  logic                  w_reg_write;
  logic                  w_misaligned;

  // Stage register: reset beats flush beats stall beats a normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_wb_sel     <= 2'b00;
      r_mem_size   <= 2'b00;
      r_mem_signed <= 1'b0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_imm16      <= 16'h0000;
      r_dest       <= 5'd0;
    end else if (bus.flush) begin
      r_valid      <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.in_valid;
      r_reg_write  <= bus.in_reg_write;
      r_wb_sel     <= bus.in_wb_sel;
      r_mem_size   <= bus.in_mem_size;
      r_mem_signed <= bus.in_mem_signed;
      r_alu        <= bus.in_alu_result;
      r_rdata      <= bus.in_mem_rdata;
      r_imm16      <= bus.in_imm16;
      r_dest       <= bus.in_dest;
    end
  end

  // Retire counter: the instruction in WB leaves when the stage is not held; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_count <= 32'd0;
    end else if (r_valid && !bus.stall) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  // Load lane extraction, extension, writeback mux and fault/forwarding decode
  always_comb begin
    w_off  = r_alu[1:0];
    w_byte = r_rdata[{w_off, 3'b000} +: 8];
    w_half = r_rdata[{w_off[1], 4'b0000} +: 16];

    case (r_mem_size)
      2'b01:   w_load = {{(data_width-16){r_mem_signed & w_half[15]}}, w_half};
      2'b10:   w_load = {{(data_width-8){r_mem_signed & w_byte[7]}}, w_byte};
      default: w_load = r_rdata;
    endcase

    case (r_wb_sel)
      2'b00:   w_write_data = r_alu;
      2'b01:   w_write_data = w_load;
      default: w_write_data = {{(data_width-16){1'b0}}, r_imm16};
    endcase

    case (r_wb_sel)
      2'b10:   w_word_pos = 2'b10;
      2'b11:   w_word_pos = 2'b01;
      default: w_word_pos = 2'b00;
    endcase

    w_reg_write  = r_valid & r_reg_write & (r_dest != 5'd0);

    // Data is still written on a fault; the flag only reports it
    w_misaligned = r_valid & (r_wb_sel == 2'b01) &
                   (((r_mem_size == 2'b01) & r_alu[0]) |
                    (((r_mem_size == 2'b00) | (r_mem_size == 2'b11)) & (r_alu[1:0] != 2'b00)));
  end

  // Outputs are driven from the stage registers only
  always_comb begin
    bus.write_data    = w_write_data;
    bus.write_address = r_dest;
    bus.RegWrite      = w_reg_write;
    bus.WordPosition  = w_word_pos;
    // Half-word writes merge into the old register value, so EX cannot take them
    bus.fwd_valid     = w_reg_write & (w_word_pos == 2'b00);
    bus.fwd_hazard    = w_reg_write & (w_word_pos != 2'b00);
    bus.fwd_dest      = r_dest;
    bus.fwd_data      = w_write_data;
    bus.misaligned    = w_misaligned;
    bus.retired_count = r_retired_count;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic clk;
  logic rst;
  int   tests;
  int   failures;

  mem_wb_stage_if #(.data_width(32)) bus ();

  mem_wb_stage #(.data_width(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_wb_sel     = 2'b00;
    bus.in_mem_size   = 2'b00;
    bus.in_mem_signed = 1'b0;
    bus.in_alu_result = 32'h0;
    bus.in_mem_rdata  = 32'h0;
    bus.in_imm16      = 16'h0;
    bus.in_dest       = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'hDEADBEEF; bus.in_dest = 5'd9;
    rst = 1'b1;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.WordPosition !== 2'b00) begin failures++; $display("FAIL reset_wordpos: got %h want 0", bus.WordPosition); end
    tests++; if (bus.write_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", bus.write_data); end
    tests++; if (bus.write_address !== 5'd0) begin failures++; $display("FAIL reset_addr: got %h want 0", bus.write_address); end
    tests++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid: got %h want 0", bus.fwd_valid); end
    tests++; if (bus.fwd_hazard !== 1'b0) begin failures++; $display("FAIL reset_fwd_hazard: got %h want 0", bus.fwd_hazard); end
    tests++; if (bus.misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %h want 0", bus.misaligned); end
    tests++; if (bus.retired_count !== 32'h0) begin failures++; $display("FAIL reset_count: got %h want 0", bus.retired_count); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_alu_write();
    do_reset();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'b00;
    bus.in_alu_result = 32'h12345678; bus.in_dest = 5'd5;
    step();
    tests++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL alu_regwrite: got %h want 1", bus.RegWrite); end
    tests++; if (bus.write_address !== 5'd5) begin failures++; $display("FAIL alu_addr: got %h want 05", bus.write_address); end
    tests++; if (bus.write_data !== 32'h12345678) begin failures++; $display("FAIL alu_data: got %h want 12345678", bus.write_data); end
    tests++; if (bus.WordPosition !== 2'b00) begin failures++; $display("FAIL alu_wordpos: got %h want 0", bus.WordPosition); end
    tests++; if (bus.fwd_valid !== 1'b1) begin failures++; $display("FAIL alu_fwd_valid: got %h want 1", bus.fwd_valid); end
    tests++; if (bus.fwd_hazard !== 1'b0) begin failures++; $display("FAIL alu_fwd_hazard: got %h want 0", bus.fwd_hazard); end
    tests++; if (bus.fwd_dest !== 5'd5) begin failures++; $display("FAIL alu_fwd_dest: got %h want 05", bus.fwd_dest); end
    tests++; if (bus.fwd_data !== 32'h12345678) begin failures++; $display("FAIL alu_fwd_data: got %h want 12345678", bus.fwd_data); end
    tests++; if (bus.retired_count !== 32'd0) begin failures++; $display("FAIL alu_count_inflight: got %h want 0", bus.retired_count); end
    idle_inputs();
    step();
    tests++; if (bus.retired_count !== 32'd1) begin failures++; $display("FAIL alu_count_retired: got %h want 1", bus.retired_count); end
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL alu_bubble_regwrite: got %h want 0", bus.RegWrite); end
  endtask

  task automatic test_load_extract();
    // size, signed, offset, expected data, expected misaligned; rdata = 80FF7F01
    logic [1:0]  t_size [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11};
    logic        t_sgn  [12] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [1:0]  t_off  [12] = '{2'd3,  2'd3,  2'd0,  2'd1,  2'd2,  2'd2,  2'd0,  2'd1,  2'd0,  2'd2,  2'd0,  2'd1};
    logic [31:0] t_exp  [12] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                 32'hFFFF80FF, 32'h00007F01, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01,
                                 32'h80FF7F01, 32'h80FF7F01};
    logic        t_mis  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'b01;
      bus.in_mem_size = t_size[i]; bus.in_mem_signed = t_sgn[i];
      bus.in_alu_result = {28'h1000000, 2'b00, t_off[i]};
      bus.in_mem_rdata = 32'h80FF7F01; bus.in_dest = 5'd9;
      step();
      tests++; if (bus.write_data !== t_exp[i]) begin failures++; $display("FAIL load_data[%0d]: got %h want %h", i, bus.write_data, t_exp[i]); end
      tests++; if (bus.misaligned !== t_mis[i]) begin failures++; $display("FAIL load_misaligned[%0d]: got %h want %h", i, bus.misaligned, t_mis[i]); end
      tests++; if (bus.fwd_valid !== 1'b1) begin failures++; $display("FAIL load_fwd_valid[%0d]: got %h want 1", i, bus.fwd_valid); end
    end
    bus.in_valid = 1'b0;
    step();
    tests++; if (bus.misaligned !== 1'b0) begin failures++; $display("FAIL misaligned_needs_valid: got %h want 0", bus.misaligned); end
    idle_inputs();
  endtask

  task automatic test_half_imm();
    do_reset();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'b10;
    bus.in_imm16 = 16'hABCD; bus.in_alu_result = 32'h55555555; bus.in_dest = 5'd7;
    step();
    tests++; if (bus.WordPosition !== 2'b10) begin failures++; $display("FAIL upper_wordpos: got %h want 2", bus.WordPosition); end
    tests++; if (bus.write_data !== 32'h0000ABCD) begin failures++; $display("FAIL upper_data: got %h want 0000abcd", bus.write_data); end
    tests++; if (bus.fwd_hazard !== 1'b1) begin failures++; $display("FAIL upper_fwd_hazard: got %h want 1", bus.fwd_hazard); end
    tests++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL upper_fwd_valid: got %h want 0", bus.fwd_valid); end
    tests++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL upper_regwrite: got %h want 1", bus.RegWrite); end
    bus.in_wb_sel = 2'b11; bus.in_imm16 = 16'h1234;
    step();
    tests++; if (bus.WordPosition !== 2'b01) begin failures++; $display("FAIL lower_wordpos: got %h want 1", bus.WordPosition); end
    tests++; if (bus.write_data !== 32'h00001234) begin failures++; $display("FAIL lower_data: got %h want 00001234", bus.write_data); end
    tests++; if (bus.fwd_hazard !== 1'b1) begin failures++; $display("FAIL lower_fwd_hazard: got %h want 1", bus.fwd_hazard); end
    bus.in_reg_write = 1'b0;
    step();
    tests++; if (bus.fwd_hazard !== 1'b0) begin failures++; $display("FAIL nowrite_fwd_hazard: got %h want 0", bus.fwd_hazard); end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'h0000BEEF; bus.in_dest = 5'd0;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL zero_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL zero_fwd_valid: got %h want 0", bus.fwd_valid); end
    bus.in_reg_write = 1'b0; bus.in_dest = 5'd4;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL nowrite_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.retired_count !== 32'd1) begin failures++; $display("FAIL zero_count: got %h want 1", bus.retired_count); end
    idle_inputs();
    step();
    tests++; if (bus.retired_count !== 32'd2) begin failures++; $display("FAIL nowrite_count: got %h want 2", bus.retired_count); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'hCAFE0001; bus.in_dest = 5'd3;
    step();
    bus.stall = 1'b1;
    bus.in_alu_result = 32'h11111111; bus.in_dest = 5'd12; bus.in_wb_sel = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.write_data !== 32'hCAFE0001) begin failures++; $display("FAIL stall_data[%0d]: got %h want cafe0001", i, bus.write_data); end
      tests++; if (bus.write_address !== 5'd3) begin failures++; $display("FAIL stall_addr[%0d]: got %h want 03", i, bus.write_address); end
      tests++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL stall_regwrite[%0d]: got %h want 1", i, bus.RegWrite); end
      tests++; if (bus.retired_count !== 32'd0) begin failures++; $display("FAIL stall_count[%0d]: got %h want 0", i, bus.retired_count); end
    end
    idle_inputs();
    step();
    tests++; if (bus.retired_count !== 32'd1) begin failures++; $display("FAIL release_count: got %h want 1", bus.retired_count); end
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'h00000042; bus.in_dest = 5'd8;
    step();
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL flush_stall_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.retired_count !== 32'd1) begin failures++; $display("FAIL flush_stall_count: got %h want 1", bus.retired_count); end
    bus.stall = 1'b0; bus.flush = 1'b0;
    step();
    bus.flush = 1'b1;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL flush_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.retired_count !== 32'd2) begin failures++; $display("FAIL flush_count: got %h want 2", bus.retired_count); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_retired_count = 32'hFFFFFFFF;
    #1;
    release dut.r_retired_count;
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_alu_result = 32'h7; bus.in_dest = 5'd2;
    step();
    tests++; if (bus.retired_count !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_preset: got %h want ffffffff", bus.retired_count); end
    idle_inputs();
    step();
    tests++; if (bus.retired_count !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h want 0", bus.retired_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'b11;
    bus.in_imm16 = 16'h00FF; bus.in_dest = 5'd17;
    step();
    bus.stall = 1'b1;
    step();
    tests++; if (bus.fwd_hazard !== 1'b1) begin failures++; $display("FAIL prerst_hazard: got %h want 1", bus.fwd_hazard); end
    rst = 1'b1;
    step();
    tests++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL rststall_regwrite: got %h want 0", bus.RegWrite); end
    tests++; if (bus.write_data !== 32'h0) begin failures++; $display("FAIL rststall_data: got %h want 0", bus.write_data); end
    tests++; if (bus.write_address !== 5'd0) begin failures++; $display("FAIL rststall_addr: got %h want 0", bus.write_address); end
    tests++; if (bus.WordPosition !== 2'b00) begin failures++; $display("FAIL rststall_wordpos: got %h want 0", bus.WordPosition); end
    tests++; if (bus.fwd_hazard !== 1'b0) begin failures++; $display("FAIL rststall_hazard: got %h want 0", bus.fwd_hazard); end
    tests++; if (bus.retired_count !== 32'h0) begin failures++; $display("FAIL rststall_count: got %h want 0", bus.retired_count); end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_write();
    test_load_extract();
    test_half_imm();
    test_zero_reg();
    test_stall_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
